// File: rtl/config_source_arbiter.sv
// Arbitrates the eFPGA config write port between bitstream sources, one whole bitstream per grant.
// Optional CONFIG_ARB_CHECKSUM_EN gates boot_o on a zero mod-2^32 sum of all accepted words.
module config_source_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned COUNT_WIDTH    = 24,
  localparam int unsigned OWNER_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WORD_WIDTH-1:0]         efpga_write_data_o,
  output logic                          efpga_write_strobe_o,
  output logic                          boot_o,
  output logic                          busy_o,
  output logic [OWNER_W-1:0]            owner_o,
  output logic [COUNT_WIDTH-1:0]        word_count_o,
  output logic                          timeout_o,
  output logic                          csum_err_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WORD_WIDTH-1:0]  data_q, data_d;
  logic                   strobe_q, strobe_d;
  logic                   boot_q, boot_d;
  logic                   timeout_q, timeout_d;

  logic                   accept;
  logic [WORD_WIDTH-1:0]  acc_word;
  logic [OWNER_W-1:0]     owner_inc;
  logic                   grant_any;
  logic [OWNER_W-1:0]     grant_idx;
  int unsigned            cand;

`ifdef CONFIG_ARB_CHECKSUM_EN
  logic [31:0] csum_q, csum_d, csum_acc;
  logic        cerr_q, cerr_d;

  assign csum_acc = csum_q + 32'(acc_word);
`endif

  assign accept    = (state_q == StLocked) && req_valid_i[owner_q];
  assign acc_word  = req_data_i[owner_q*WORD_WIDTH +: WORD_WIDTH];
  assign owner_inc = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  // Round-robin search: first valid source at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = OWNER_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tmo_d     = tmo_q;
    count_d   = count_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    boot_d    = boot_q;
    timeout_d = 1'b0;
`ifdef CONFIG_ARB_CHECKSUM_EN
    csum_d    = csum_q;
    cerr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = StLocked;
          owner_d = grant_idx;
          count_d = '0;
          boot_d  = 1'b0;
          tmo_d   = '0;
`ifdef CONFIG_ARB_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLocked: begin
        // An accept always beats a coincident timeout expiry.
        if (accept) begin
          data_d   = acc_word;
          strobe_d = 1'b1;
          tmo_d    = '0;
          if (!(&count_q)) count_d = count_q + COUNT_WIDTH'(1);
`ifdef CONFIG_ARB_CHECKSUM_EN
          csum_d = csum_acc;
`endif
          if (req_last_i[owner_q]) begin
            state_d = StIdle;
            ptr_d   = owner_inc;
`ifdef CONFIG_ARB_CHECKSUM_EN
            if (csum_acc == 32'd0) boot_d = 1'b1;
            else                   cerr_d = 1'b1;
`else
            boot_d  = 1'b1;
`endif
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          ptr_d     = owner_inc;
          tmo_d     = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      ptr_q     <= '0;
      tmo_q     <= '0;
      count_q   <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      boot_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CONFIG_ARB_CHECKSUM_EN
      csum_q    <= '0;
      cerr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tmo_q     <= tmo_d;
      count_q   <= count_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      boot_q    <= boot_d;
      timeout_q <= timeout_d;
`ifdef CONFIG_ARB_CHECKSUM_EN
      csum_q    <= csum_d;
      cerr_q    <= cerr_d;
`endif
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StLocked) req_ready_o[owner_q] = 1'b1;
  end

  assign efpga_write_data_o   = data_q;
  assign efpga_write_strobe_o = strobe_q;
  assign boot_o               = boot_q;
  assign busy_o               = (state_q == StLocked);
  assign owner_o              = owner_q;
  assign word_count_o         = count_q;
  assign timeout_o            = timeout_q;
`ifdef CONFIG_ARB_CHECKSUM_EN
  assign csum_err_o           = cerr_q;
`else
  assign csum_err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_config_source_arbiter.sv
// Self-checking bench for config_source_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_config_source_arbiter;

  localparam int unsigned N   = 3;
  localparam int unsigned W   = 32;
  localparam int unsigned Tmo = 16;
  localparam int unsigned CW  = 4;
  localparam int unsigned OW  = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [W-1:0]  wr_data;
  logic          wr_strobe, boot, busy, tmo, cerr;
  logic [OW-1:0] owner;
  logic [CW-1:0] wcount;

  always #5 clk = ~clk;

  config_source_arbiter #(
    .NUM_REQ        (N),
    .WORD_WIDTH     (W),
    .TIMEOUT_CYCLES (Tmo),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .req_data_i           (req_data),
    .req_valid_i          (req_valid),
    .req_last_i           (req_last),
    .req_ready_o          (req_ready),
    .efpga_write_data_o   (wr_data),
    .efpga_write_strobe_o (wr_strobe),
    .boot_o               (boot),
    .busy_o               (busy),
    .owner_o              (owner),
    .word_count_o         (wcount),
    .timeout_o            (tmo),
    .csum_err_o           (cerr)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the port, where the pointer is, and what the
  // outputs should show after the most recent clock edge.
  bit          m_locked, m_strobe, m_boot, m_tmo, m_cerr;
  int unsigned m_owner, m_ptr, m_idle, m_count;
  logic [31:0] m_data, m_sum;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_strobe = 0; m_boot = 0; m_tmo = 0; m_cerr = 0;
    m_owner = 0; m_ptr = 0; m_idle = 0; m_count = 0; m_data = '0; m_sum = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic [N-1:0] l,
                            input logic [N*W-1:0] d, input logic r);
    logic [31:0] w;
    bit found;
    if (r) begin
      model_reset();
      return;
    end
    m_strobe = 0; m_tmo = 0; m_cerr = 0;
    if (!m_locked) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int unsigned j;
        j = (m_ptr + k) % N;
        if (!found && v[j]) begin
          found = 1;
          m_owner = j; m_count = 0; m_boot = 0; m_locked = 1; m_idle = 0; m_sum = '0;
        end
      end
    end else if (v[m_owner]) begin
      w = d[m_owner*W +: W];
      m_data = w;
      m_strobe = 1;
      m_idle = 0;
      m_count = (m_count + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_count + 1;
      m_sum = m_sum + w;
      if (l[m_owner]) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % N;
`ifdef CONFIG_ARB_CHECKSUM_EN
        m_boot = (m_sum == 0);
        m_cerr = (m_sum != 0);
`else
        m_boot = 1;
`endif
      end
    end else begin
      m_idle++;
      if (m_idle == Tmo) begin
        m_tmo = 1; m_locked = 0; m_idle = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] er;
    er = '0;
    if (m_locked) er[m_owner] = 1'b1;
    check_val("ready", req_ready, er);
    check_val("strobe", wr_strobe, m_strobe);
    check_val("data", wr_data, m_data);
    check_val("boot", boot, m_boot);
    check_val("busy", busy, m_locked);
    check_val("owner", owner, m_owner);
    check_val("count", wcount, m_count);
    check_val("timeout", tmo, m_tmo);
    check_val("csum_err", cerr, m_cerr);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*W-1:0] d, input logic r);
    @(negedge clk);
    if (chk_en) compare_all();
    req_valid = v;
    req_last  = l;
    req_data  = d;
    reset_i   = r;
    model_edge(v, l, d, r);
    @(posedge clk);
  endtask

  function automatic logic [N*W-1:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2);
    return {w2, w1, w0};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb;
    int prob[N];
    logic [N-1:0]  v, l;
    logic [N*W-1:0] d;

    reset_i = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    repeat (2) @(posedge clk);
    model_reset();
    chk_en = 1'b1;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_boot", boot, 0);
    check_val("rst_strobe", wr_strobe, 0);
    check_val("rst_ready", req_ready, 0);

    // Single source, three back-to-back words.
    step(3'b001, 3'b000, pack(32'h1, 0, 0), 0);
    step(3'b001, 3'b000, pack(32'h1, 0, 0), 0);
    step(3'b001, 3'b000, pack(32'h2, 0, 0), 0);
    step(3'b001, 3'b001, pack(32'hFFFF_FFFD, 0, 0), 0);
    #1;
    check_val("s1_strobe", wr_strobe, 1);
    check_val("s1_data", wr_data, 32'hFFFF_FFFD);
    check_val("s1_boot", boot, 1);
    check_val("s1_count", wcount, 3);
    check_val("s1_busy", busy, 0);
    step(3'b000, 3'b000, '0, 0);

    // Two contending sources after reset.
    step(3'b000, 3'b000, '0, 1);
    step(3'b011, 3'b000, pack(32'hA0, 32'hB0, 0), 0);
    #1;
    check_val("s2_owner0", owner, 0);
    check_val("s2_ready0", req_ready, 3'b001);
    step(3'b011, 3'b000, pack(32'hA0, 32'hB0, 0), 0);
    step(3'b011, 3'b001, pack(32'hA1, 32'hB0, 0), 0);
    step(3'b010, 3'b000, pack(0, 32'hB0, 0), 0);
    #1;
    check_val("s2_owner1", owner, 1);
    check_val("s2_ready1", req_ready, 3'b010);
    step(3'b010, 3'b010, pack(0, 32'hB0, 0), 0);

    // Timeout: source 0 sends one word and goes silent while source 1 waits.
    step(3'b000, 3'b000, '0, 1);
    step(3'b001, 3'b000, pack(32'h55, 0, 0), 0);
    step(3'b001, 3'b000, pack(32'h55, 0, 0), 0);
    for (int i = 1; i <= Tmo; i++) begin
      step(3'b010, 3'b000, pack(0, 32'h66, 0), 0);
      #1;
      check_val("s3_timeout", tmo, (i == Tmo));
    end
    check_val("s3_boot", boot, 0);
    step(3'b011, 3'b000, pack(32'h55, 32'h66, 0), 0);
    #1;
    check_val("s3_next_owner", owner, 1);
    step(3'b010, 3'b010, pack(0, 32'h66, 0), 0);

    // Reset while the second of four words is accepted.
    step(3'b000, 3'b000, '0, 1);
    step(3'b001, 3'b001, pack(32'h5, 0, 0), 0);
    step(3'b001, 3'b001, pack(32'h5, 0, 0), 0);
    step(3'b011, 3'b000, pack(0, 32'h7, 0), 0);
    step(3'b010, 3'b000, pack(0, 32'h7, 0), 0);
    step(3'b010, 3'b000, pack(0, 32'h8, 0), 1);
    #1;
    check_val("s4_busy", busy, 0);
    check_val("s4_strobe", wr_strobe, 0);
    check_val("s4_data", wr_data, 0);
    check_val("s4_count", wcount, 0);
    check_val("s4_owner", owner, 0);
    step(3'b011, 3'b000, pack(32'h9, 32'h8, 0), 0);
    #1;
    check_val("s4_regrant", req_ready, 3'b001);
    step(3'b001, 3'b001, pack(32'h9, 0, 0), 0);

    // Owner toggles valid every other cycle.
    step(3'b000, 3'b000, '0, 1);
    step(3'b001, 3'b000, pack(32'h10, 0, 0), 0);
    nstb = 0;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? 3'b001 : 3'b000;
      l = (i == 6) ? 3'b001 : 3'b000;
      step(v, l, pack(32'h10 + 32'(i / 2), 0, 0), 0);
      #1;
      check_val("s5_strobe", wr_strobe, (i % 2 == 0));
      nstb += int'(wr_strobe);
    end
    step(3'b000, 3'b000, '0, 0);
    #1;
    nstb += int'(wr_strobe);
    check_val("s5_total", nstb, 4);

    // Bad checksum on the last word.
    step(3'b100, 3'b000, pack(0, 0, 32'h1), 0);
    step(3'b100, 3'b000, pack(0, 0, 32'h1), 0);
    step(3'b100, 3'b000, pack(0, 0, 32'h2), 0);
    step(3'b100, 3'b100, pack(0, 0, 32'hFFFF_FFFC), 0);
    #1;
    check_val("s6_strobe", wr_strobe, 1);
`ifdef CONFIG_ARB_CHECKSUM_EN
    check_val("s6_csum_err", cerr, 1);
    check_val("s6_boot", boot, 0);
`else
    check_val("s6_csum_err", cerr, 0);
    check_val("s6_boot", boot, 1);
`endif

    // Randomized traffic with per-block source activity levels.
    for (int blk = 0; blk < 60; blk++) begin
      for (int s = 0; s < N; s++) begin
        case ($urandom_range(0, 2))
          0:       prob[s] = 0;
          1:       prob[s] = 40;
          default: prob[s] = 95;
        endcase
      end
      for (int c = 0; c < 50; c++) begin
        for (int s = 0; s < N; s++) begin
          v[s] = ($urandom_range(0, 99) < prob[s]);
          l[s] = ($urandom_range(0, 99) < 15);
          d[s*W +: W] = $urandom();
        end
        step(v, l, d, ($urandom_range(0, 299) == 0));
      end
    end
    step(3'b000, 3'b000, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_source_arbiter.md
Name: config_source_arbiter

Overview:
Shares the single eFPGA configuration write port (32-bit word plus write strobe) between several bitstream sources, for example the USB-CDC config channel and a JTAG-side loader. A source is granted the port for a whole bitstream. Each accepted word is forwarded as one strobe. The block raises boot_o after a complete bitstream and aborts a stalled owner on timeout. It sits between the word-assembling source blocks and the eFPGA config interface, in the system clock domain.

Parameters:
NUM_REQ, 2, number of requesting sources (>=2)
WORD_WIDTH, 32, configuration word width
TIMEOUT_CYCLES, 1200000, idle cycles allowed for the owner before abort (100 ms at 12 MHz)
COUNT_WIDTH, 24, width of the accepted-word counter
OWNER_W, $clog2(NUM_REQ), width of owner_o (localparam)

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
req_data_i  input  NUM_REQ*WORD_WIDTH  per-source word; source k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]
req_valid_i  input  NUM_REQ  per-source word valid
req_last_i  input  NUM_REQ  marks the final word of a bitstream; qualified by valid
req_ready_o  output  NUM_REQ  per-source ready
efpga_write_data_o  output  WORD_WIDTH  word to the eFPGA config port
efpga_write_strobe_o  output  1  one-cycle write strobe per forwarded word
boot_o  output  1  bitstream completed successfully
busy_o  output  1  a source currently owns the port
owner_o  output  OWNER_W  index of the current or most recent owner
word_count_o  output  COUNT_WIDTH  words accepted in the current or last bitstream
timeout_o  output  1  one-cycle pulse on owner timeout abort
csum_err_o  output  1  one-cycle pulse on checksum failure (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high on reset_i.
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer 0; timeout counter 0.
- Reset mid-bitstream: on the next edge, ownership is dropped, no further strobes are issued, and boot_o is 0. A partial bitstream is not resumed.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - When any req_valid_i bit is set, grant the first set bit at or after the round-robin pointer, wrapping past NUM_REQ-1 to 0.
  - On the grant edge: owner_o is latched, word_count_o is cleared, boot_o is cleared, the state goes to LOCKED, and busy_o becomes 1.
  - No word is accepted in the grant cycle.
- LOCKED:
  - req_ready_o[owner]=1. All other ready bits are 0, and other sources' valid is ignored.
  - req_ready_o is decoded from registers only; there is no combinational path from valid.
- Accept: a word is accepted when req_valid_i[owner] && req_ready_o[owner]. Maximum throughput is one word per cycle.
- Forward latency: 1 cycle. The cycle after an accept, efpga_write_data_o holds the word and efpga_write_strobe_o=1. Otherwise strobe=0 and the data output holds its last value.
- word_count_o increments on each accept and saturates at all-ones.
- Accepting a word with req_last_i set:
  - Next state is IDLE; busy_o=0 and ready=0 from the next cycle.
  - The round-robin pointer becomes owner+1, wrapping to 0.
  - boot_o rises together with the strobe of the last word and stays high until the next grant or reset.
- Timeout:
  - The counter clears on every accept and on grant, and increments each LOCKED cycle without an accept.
  - When it reaches TIMEOUT_CYCLES: timeout_o pulses one cycle, state goes to IDLE, boot_o stays 0, and the pointer advances to owner+1.
- Simultaneous accept and timeout expiry: the accept wins and the counter clears.
- After returning to IDLE, a new grant can occur on the following edge.

Optional Feature:
CONFIG_ARB_CHECKSUM_EN
- With the macro:
  - A 32-bit running sum (mod 2^32) of every accepted word, including the last, is kept; it is cleared on grant.
  - On the last word, boot_o is set only if the sum equals 0. Otherwise csum_err_o pulses for one cycle, aligned with the last strobe, and boot_o stays 0.
  - All words are still forwarded.
- Without the macro: no sum logic is built, csum_err_o is tied to 0, and boot_o is set on every last word.

Test Plan:
- Single source, words 0x1, 0x2, last 0xFFFFFFFD sent back-to-back:
  - Three strobes on consecutive cycles, each one cycle after its accept; data 0x1, 0x2, 0xFFFFFFFD.
  - boot_o=1 with the third strobe; word_count_o=3; busy_o=0 afterwards.
- Both sources valid in IDLE after reset:
  - Source 0 is granted and req_ready_o[1]=0 throughout.
  - After source 0's last word, source 1 is granted on the next edge.
  - owner_o changes 0 to 1.
- TIMEOUT_CYCLES=16, owner sends one word then drops valid:
  - timeout_o pulses 16 cycles after the accept; boot_o=0; next grant goes to the other source if it is valid.
- reset_i asserted for one cycle while the second of four words is accepted:
  - The next cycle has all outputs at 0 and no strobe.
  - Subsequent bitstreams start from pointer 0.
- Owner toggles valid every other cycle with 4 words: exactly 4 strobes, only on cycles following accepts.
- CONFIG_ARB_CHECKSUM_EN defined, last word changed to 0xFFFFFFFC: csum_err_o pulses with the third strobe and boot_o stays 0.
